led_mmio_port: RTL and testbench
================================

Name: led_mmio_port

Overview:
- Memory-mapped LED output peripheral; bus responder for the CPU's load/store interface.
- CPU stores to a small register window; block drives the board LEDS (active-low).
- Sits beside data memory on the CPU bus, selected by address window.
- Provides set/clear/toggle access, read-back, a write counter, and optional PWM dimming.

Parameters:
- BASE_ADDR, 32'h0000_0400, window base; must be 32-byte aligned.
- NUM_LEDS, 6, LED count (1..32).
- ADDR_W, 32, bus address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- io_addr  in  ADDR_W  byte address.
- io_wdata  in  32  store data.
- io_wstrb  in  1  single-cycle write strobe.
- io_rstrb  in  1  single-cycle read strobe.
- io_rdata  out  32  read data, valid while io_ready=1.
- io_ready  out  1  one-cycle acknowledge.
- io_busy  out  1  high while an access is in progress.
- LEDS  out  NUM_LEDS  LED pads, active-low (0 = lit).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (rst=0 sampled at a clk edge):
  - led_reg=0, duty=8'hFF, wr_count=0, err=0, state=IDLE.
  - io_ready=0, io_busy=0, io_rdata=0, LEDS all 1 (all off).
- Select: sel = strobe && io_addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]. Strobes outside the window are ignored entirely and get no ack.
- Register map (byte offset io_addr[4:0]):
  - 0x00 LED_OUT: RW, data[NUM_LEDS-1:0].
  - 0x04 LED_SET: W1S; reads 0.
  - 0x08 LED_CLR: W1C; reads 0.
  - 0x0C LED_TGL: write-1-toggle; reads 0.
  - 0x10 PWM_DUTY: RW, data[7:0].
  - 0x14 STATUS: RO, {15'b0, err, wr_count[15:0]}.
  - Other offsets: writes ignored, reads 0; still acknowledged.
  - Unused upper data bits read 0.
- FSM (2 states):
  - IDLE: on sel, latch the access, apply the write at this edge, capture read data, go to ACK. io_busy=0.
  - ACK: io_ready=1 and io_busy=1 for exactly one cycle, then return to IDLE.
  - Latency: strobe at cycle N gives io_ready at N+1. Back-to-back accesses are possible every 2 cycles.
- Strobe while in ACK: dropped with no effect and no ack; sets sticky err. err is cleared only by a write to STATUS or by reset.
- wstrb and rstrb asserted together: one ack. The write is applied, and io_rdata returns the pre-write value.
- wr_count:
  - Increments on every acknowledged write, including unmapped offsets.
  - Wraps 16'hFFFF to 0.
  - A STATUS write clears err only; wr_count is unaffected.
- io_rdata holds 0 when io_ready=0.
- LED_SET, LED_CLR and LED_TGL act only on bits [NUM_LEDS-1:0].
- LEDS = ~(led_reg & pwm_on) when the optional feature is present, else ~led_reg. Registered, so LEDS updates one cycle after the write edge.
- Reset asserted mid-access (in ACK): the next edge forces IDLE; the pending ack is not delivered.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - 8-bit free-running pwm_cnt (0..254, wraps to 0).
  - pwm_on = (pwm_cnt < duty) || (duty == 8'hFF).
  - duty=0 turns all LEDs off, 8'hFF holds them fully on; period is 255 clks.
- Undefined:
  - No counter; PWM_DUTY writes ignored and reads 0.
  - LEDS driven directly from led_reg.

Decomposition:
- Package led_mmio_pkg holds:
  - register offset localparams (OFF_OUT, OFF_SET, OFF_CLR, OFF_TGL, OFF_DUTY, OFF_STATUS).
  - FSM state encoding (ST_IDLE, ST_ACK).
  - PWM_PERIOD=255.
- One sub-module: led_pwm_gen (counter and compare, produces pwm_on). Instantiated only under LED_PWM_EN.

Test Plan:
- Reset: hold rst=0 for 3 clks -> LEDS=6'b111111, io_ready=0, STATUS read returns 0.
- Write then read: write LED_OUT=0x2A -> io_ready at N+1; one cycle later LEDS=6'b010101; read LED_OUT returns 0x0000002A.
- Set/clear/toggle from led_reg=0x2A:
  - SET 0x01 -> 0x2B.
  - CLR 0x08 -> 0x23.
  - TGL 0x3F -> 0x1C.
  - Expected after the sequence: LEDS=6'b100011; STATUS wr_count=4.
- Protocol errors:
  - Strobe during ACK -> no second ack, STATUS err=1.
  - Write to STATUS -> err=0, wr_count unchanged.
  - Address BASE+0x40 -> never acknowledged.
- Simultaneous read and write to LED_OUT (old 0x05, new 0x30) -> io_rdata=0x05, then led_reg=0x30.
- PWM (LED_PWM_EN only): LED_OUT=0x3F, duty=64 -> each LED low for 64 of every 255 clks; duty=0 -> LEDS stay 6'b111111.

Source files
------------

// File: rtl/led_mmio_pkg.sv
// Shared definitions for the LED MMIO port: register offsets, FSM states, status layout.
package led_mmio_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned OFF_W      = 5;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned DUTY_W     = 8;
    localparam int unsigned PWM_PERIOD = 255;

    localparam logic [OFF_W-1:0] OFF_OUT    = 5'h00;
    localparam logic [OFF_W-1:0] OFF_SET    = 5'h04;
    localparam logic [OFF_W-1:0] OFF_CLR    = 5'h08;
    localparam logic [OFF_W-1:0] OFF_TGL    = 5'h0C;
    localparam logic [OFF_W-1:0] OFF_DUTY   = 5'h10;
    localparam logic [OFF_W-1:0] OFF_STATUS = 5'h14;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    // STATUS register read layout
    typedef struct packed {
        logic [14:0]      rsvd;
        logic             err;
        logic [CNT_W-1:0] wr_count;
    } status_t;

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter and duty compare for LED dimming.
// Exists only when LED_PWM_EN is defined.
`ifdef LED_PWM_EN
module led_pwm_gen
    import led_mmio_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty_i,
    output logic              pwm_on_o
);

    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              on_q, on_d;

    // Counter runs 0..PWM_PERIOD-1; full-scale duty forces steady on
    always_comb begin
        cnt_d = (cnt_q == DUTY_W'(PWM_PERIOD - 1)) ? '0 : cnt_q + DUTY_W'(1);
        on_d  = (cnt_q < duty_i) || (duty_i == '1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            on_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            on_q  <= on_d;
        end
    end

    assign pwm_on_o = on_q;

endmodule
`endif

// File: rtl/led_mmio_port.sv
// Memory-mapped LED output port with set/clear/toggle, read-back and write counter.
// Optional PWM dimming is built when LED_PWM_EN is defined.
module led_mmio_port
    import led_mmio_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0400),
    parameter int unsigned       NUM_LEDS  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   io_addr,
    input  logic [DATA_W-1:0]   io_wdata,
    input  logic                io_wstrb,
    input  logic                io_rstrb,
    output logic [DATA_W-1:0]   io_rdata,
    output logic                io_ready,
    output logic                io_busy,
    output logic [NUM_LEDS-1:0] LEDS
);

    state_e              state_q, state_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic [CNT_W-1:0]    wr_count_q, wr_count_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                sel_c;
    logic [OFF_W-1:0]    off_c;
    logic [NUM_LEDS-1:0] wbits_c;
    logic [NUM_LEDS-1:0] pwm_mask_c;
    logic [DATA_W-1:0]   rd_val_c;
    status_t             status_c;
    logic                unused_wdata;

    assign sel_c   = (io_wstrb || io_rstrb)
                     && (io_addr[ADDR_W-1:OFF_W] == BASE_ADDR[ADDR_W-1:OFF_W]);
    assign off_c   = io_addr[OFF_W-1:0];
    assign wbits_c = io_wdata[NUM_LEDS-1:0];
    assign unused_wdata = ^io_wdata;

    assign status_c = '{rsvd: '0, err: err_q, wr_count: wr_count_q};

`ifdef LED_PWM_EN
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              pwm_on;

    led_pwm_gen u_pwm (
        .clk      (clk),
        .rst      (rst),
        .duty_i   (duty_q),
        .pwm_on_o (pwm_on)
    );

    assign pwm_mask_c = {NUM_LEDS{pwm_on}};
`else
    assign pwm_mask_c = '1;
`endif

    // Read mux reflects register contents before any same-edge write
    always_comb begin
        rd_val_c = '0;
        case (off_c)
            OFF_OUT:    rd_val_c = DATA_W'(led_q);
`ifdef LED_PWM_EN
            OFF_DUTY:   rd_val_c = DATA_W'(duty_q);
`endif
            OFF_STATUS: rd_val_c = DATA_W'(status_c);
            default:    rd_val_c = '0;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        wr_count_d = wr_count_q;
        err_d      = err_q;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        rdata_d    = '0;
        leds_d     = ~(led_q & pwm_mask_c);
`ifdef LED_PWM_EN
        duty_d     = duty_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_c) begin
                    state_d = ST_ACK;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                    rdata_d = io_rstrb ? rd_val_c : '0;
                    if (io_wstrb) begin
                        if (off_c != OFF_STATUS) begin
                            wr_count_d = wr_count_q + CNT_W'(1);
                        end
                        case (off_c)
                            OFF_OUT:    led_d = wbits_c;
                            OFF_SET:    led_d = led_q | wbits_c;
                            OFF_CLR:    led_d = led_q & ~wbits_c;
                            OFF_TGL:    led_d = led_q ^ wbits_c;
`ifdef LED_PWM_EN
                            OFF_DUTY:   duty_d = io_wdata[DUTY_W-1:0];
`endif
                            OFF_STATUS: err_d = 1'b0;
                            default:    ;
                        endcase
                    end
                end
            end
            ST_ACK: begin
                // A selected strobe here is dropped and flagged
                state_d = ST_IDLE;
                if (sel_c) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            led_q      <= '0;
            leds_q     <= '1;
            wr_count_q <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
`ifdef LED_PWM_EN
            duty_q     <= '1;
`endif
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            leds_q     <= leds_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
`ifdef LED_PWM_EN
            duty_q     <= duty_d;
`endif
        end
    end

    assign io_rdata = rdata_q;
    assign io_ready = ready_q;
    assign io_busy  = busy_q;
    assign LEDS     = leds_q;

endmodule

// File: tb/tb_led_mmio_port.sv
// Self-checking bench for led_mmio_port: vector table, hand sequences, random traffic vs model.
module tb_led_mmio_port;

    localparam int unsigned NL   = 6;
    localparam logic [31:0] BASE = 32'h0000_0400;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   io_addr = '0;
    logic [31:0]   io_wdata = '0;
    logic          io_wstrb = 1'b0;
    logic          io_rstrb = 1'b0;
    logic [31:0]   io_rdata;
    logic          io_ready;
    logic          io_busy;
    logic [NL-1:0] LEDS;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the register file
    int unsigned m_led, m_duty, m_cnt;
    bit          m_err;

    led_mmio_port dut (
        .clk      (clk),
        .rst      (rst),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_wstrb (io_wstrb),
        .io_rstrb (io_rstrb),
        .io_rdata (io_rdata),
        .io_ready (io_ready),
        .io_busy  (io_busy),
        .LEDS     (LEDS)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    off;
        logic [31:0]   d;
        bit            w;
        bit            r;
        logic [31:0]   exp_rd;
        logic [NL-1:0] exp_leds;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic void model_reset();
        m_led  = 0;
        m_duty = 255;
        m_cnt  = 0;
        m_err  = 1'b0;
    endfunction

    // Returns the read value (pre-write) and applies the write
    function automatic logic [31:0] model_access(input logic [4:0] off, input logic [31:0] d,
                                                 input bit w, input bit r);
        int unsigned mask = (1 << NL) - 1;
        int unsigned rv;
        case (off)
            5'h00:   rv = m_led;
`ifdef LED_PWM_EN
            5'h10:   rv = m_duty;
`endif
            5'h14:   rv = (int'(m_err) * 65536) + m_cnt;
            default: rv = 0;
        endcase
        if (w) begin
            case (off)
                5'h00: m_led = d & mask;
                5'h04: m_led = m_led | (d & mask);
                5'h08: m_led = m_led & ~d & mask;
                5'h0C: m_led = (m_led ^ d) & mask;
`ifdef LED_PWM_EN
                5'h10: m_duty = d & 255;
`endif
                5'h14: m_err = 1'b0;
                default: ;
            endcase
            if (off != 5'h14) m_cnt = (m_cnt + 1) % 65536;
        end
        return r ? rv : 0;
    endfunction

    function automatic bit leds_predictable();
        return m_duty == 255;
    endfunction

    function automatic logic [NL-1:0] model_leds();
        int unsigned v = ~m_led;
        return v[NL-1:0];
    endfunction

    // Caller is at a negedge; one access, then one settle cycle
    task automatic do_access(input logic [31:0] addr, input logic [31:0] d, input bit w, input bit r,
                             output logic ack, output logic busy, output logic [31:0] rd,
                             output logic ack2, output logic [NL-1:0] leds);
        io_addr  = addr;
        io_wdata = d;
        io_wstrb = w;
        io_rstrb = r;
        @(negedge clk);
        io_wstrb = 1'b0;
        io_rstrb = 1'b0;
        ack  = io_ready;
        busy = io_busy;
        rd   = io_rdata;
        @(negedge clk);
        ack2 = io_ready;
        leds = LEDS;
    endtask

    // In-window access checked against the model
    task automatic acc_chk(input string name, input logic [4:0] off, input logic [31:0] d,
                           input bit w, input bit r);
        logic ack, busy, ack2;
        logic [31:0] rd, exp;
        logic [NL-1:0] leds;
        exp = model_access(off, d, w, r);
        do_access(BASE | 32'(off), d, w, r, ack, busy, rd, ack2, leds);
        check({name, " ack"}, 32'(ack), 32'd1);
        check({name, " busy"}, 32'(busy), 32'd1);
        check({name, " single"}, 32'(ack2), 32'd0);
        if (r) check({name, " rdata"}, rd, exp);
        if (leds_predictable()) check({name, " leds"}, 32'(leds), 32'(model_leds()));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        io_wstrb = 1'b0;
        io_rstrb = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic ack, busy, ack2;
        logic [31:0] rd;
        logic [NL-1:0] leds;
        int seen;

        // Reset
        model_reset();
        do_reset(3);
        check("reset leds", 32'(LEDS), 32'h3F);
        check("reset ready", 32'(io_ready), 32'd0);
        check("reset busy", 32'(io_busy), 32'd0);
        check("reset rdata", io_rdata, 32'd0);
        acc_chk("reset status", 5'h14, 32'd0, 1'b0, 1'b1);

        // Vector table
        vecs[0]  = '{5'h00, 32'h0000_002A, 1'b1, 1'b0, 32'h0,  6'b010101};
        vecs[1]  = '{5'h00, 32'h0,         1'b0, 1'b1, 32'h2A, 6'b010101};
        vecs[2]  = '{5'h04, 32'h0000_0001, 1'b1, 1'b0, 32'h0,  6'b010100};
        vecs[3]  = '{5'h08, 32'h0000_0008, 1'b1, 1'b0, 32'h0,  6'b011100};
        vecs[4]  = '{5'h0C, 32'h0000_003F, 1'b1, 1'b0, 32'h0,  6'b100011};
        vecs[5]  = '{5'h14, 32'h0,         1'b0, 1'b1, 32'h4,  6'b100011};
        vecs[6]  = '{5'h04, 32'h0,         1'b0, 1'b1, 32'h0,  6'b100011};
        vecs[7]  = '{5'h08, 32'h0,         1'b0, 1'b1, 32'h0,  6'b100011};
        vecs[8]  = '{5'h0C, 32'h0,         1'b0, 1'b1, 32'h0,  6'b100011};
        vecs[9]  = '{5'h18, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,  6'b100011};
        vecs[10] = '{5'h14, 32'h0,         1'b0, 1'b1, 32'h5,  6'b100011};
        vecs[11] = '{5'h04, 32'hFFFF_FFC0, 1'b1, 1'b0, 32'h0,  6'b100011};
        vecs[12] = '{5'h00, 32'h0,         1'b0, 1'b1, 32'h1C, 6'b100011};
`ifdef LED_PWM_EN
        vecs[13] = '{5'h10, 32'h0,         1'b0, 1'b1, 32'hFF, 6'b100011};
`else
        vecs[13] = '{5'h10, 32'h0,         1'b0, 1'b1, 32'h0,  6'b100011};
`endif
        vecs[14] = '{5'h08, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,  6'b111111};
        vecs[15] = '{5'h14, 32'h0,         1'b0, 1'b1, 32'h7,  6'b111111};

        for (int i = 0; i < 16; i++) begin
            void'(model_access(vecs[i].off, vecs[i].d, vecs[i].w, vecs[i].r));
            do_access(BASE | 32'(vecs[i].off), vecs[i].d, vecs[i].w, vecs[i].r,
                      ack, busy, rd, ack2, leds);
            check($sformatf("vec%0d ack", i), 32'(ack), 32'd1);
            check($sformatf("vec%0d drop", i), 32'(ack2), 32'd0);
            if (vecs[i].r) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d leds", i), 32'(leds), 32'(vecs[i].exp_leds));
        end

        // Strobe during ACK: dropped, sets err
        void'(model_access(5'h00, 32'h1, 1'b1, 1'b0));
        m_err = 1'b1;
        io_addr = BASE; io_wdata = 32'h1; io_wstrb = 1'b1;
        @(negedge clk);
        check("ack phase ready", 32'(io_ready), 32'd1);
        io_wdata = 32'h3F;
        @(negedge clk);
        io_wstrb = 1'b0;
        check("ack strobe no 2nd ack", 32'(io_ready), 32'd0);
        @(negedge clk);
        check("ack strobe still idle", 32'(io_ready), 32'd0);
        acc_chk("after drop out", 5'h00, 32'h0, 1'b0, 1'b1);
        acc_chk("err status", 5'h14, 32'h0, 1'b0, 1'b1);
        acc_chk("status write", 5'h14, 32'hFFFF_FFFF, 1'b1, 1'b0);
        acc_chk("err cleared", 5'h14, 32'h0, 1'b0, 1'b1);

        // Out-of-window strobes never acknowledged
        seen = 0;
        io_addr = BASE + 32'h40; io_wdata = 32'h3F; io_wstrb = 1'b1;
        @(negedge clk);
        io_wstrb = 1'b0;
        io_rstrb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (io_ready) seen++;
            @(negedge clk);
        end
        io_rstrb = 1'b0;
        check("window+0x40 ack", 32'(seen), 32'd0);
        acc_chk("window+0x40 no effect", 5'h00, 32'h0, 1'b0, 1'b1);

        // Simultaneous read+write returns pre-write value
        acc_chk("rw pre", 5'h00, 32'h05, 1'b1, 1'b0);
        acc_chk("rw both", 5'h00, 32'h30, 1'b1, 1'b1);
        acc_chk("rw post", 5'h00, 32'h0, 1'b0, 1'b1);

        // Reset during ACK cancels the pending ack
        io_addr = BASE; io_wdata = 32'h3F; io_wstrb = 1'b1;
        @(negedge clk);
        io_wstrb = 1'b0;
        check("pre-reset ack", 32'(io_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("reset in ack ready", 32'(io_ready), 32'd0);
        check("reset in ack busy", 32'(io_busy), 32'd0);
        check("reset in ack leds", 32'(LEDS), 32'h3F);
        rst = 1'b1;
        model_reset();
        acc_chk("post reset status", 5'h14, 32'h0, 1'b0, 1'b1);

`ifdef LED_PWM_EN
        acc_chk("pwm out", 5'h00, 32'h3F, 1'b1, 1'b0);
        acc_chk("pwm duty64", 5'h10, 32'd64, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        seen = 0;
        for (int k = 0; k < 255; k++) begin
            if (LEDS == '0) seen++;
            @(negedge clk);
        end
        check("pwm duty64 lit cycles", 32'(seen), 32'd64);
        acc_chk("pwm duty0", 5'h10, 32'd0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        seen = 0;
        for (int k = 0; k < 255; k++) begin
            if (LEDS != 6'b111111) seen++;
            @(negedge clk);
        end
        check("pwm duty0 dark", 32'(seen), 32'd0);
        acc_chk("pwm duty ff", 5'h10, 32'hFF, 1'b1, 1'b1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            int unsigned sel = $urandom_range(0, 7);
            int unsigned wr  = $urandom_range(1, 3);
            logic [31:0] d   = $urandom;
            logic [4:0]  off;
            if (sel < 6) off = 5'(sel * 4);
            else off = 5'($urandom_range(0, 31));
            if (sel == 7) begin
                logic [31:0] a = BASE ^ (32'h1 << $urandom_range(5, 31));
                do_access(a | 32'(off), d, wr[0], wr[1], ack, busy, rd, ack2, leds);
                check($sformatf("rnd%0d outside ack", i), 32'({ack, ack2}), 32'd0);
                if (leds_predictable())
                    check($sformatf("rnd%0d outside leds", i), 32'(leds), 32'(model_leds()));
            end else begin
                acc_chk($sformatf("rnd%0d", i), off, d, wr[0], wr[1]);
            end
        end
        acc_chk("final status", 5'h14, 32'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
